// File: rtl/alu.sv
// N-bit ALU: combinational pass/add/Q1.(N-1)-by-integer multiply result,
// with zero/neg/ovf flags registered under flag_en.
package cpuConfig;
  typedef enum logic [1:0] {
    ALU_A   = 2'd0,
    ALU_B   = 2'd1,
    ALU_ADD = 2'd2,
    ALU_MUL = 2'd3
  } aluFunc_t;
endpackage

module alu #(
  parameter int N      = 8,
  parameter int A_SIZE = 2
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  input  cpuConfig::aluFunc_t func,
  input  logic               flag_en,
  output logic [N-1:0]       result,
  output logic               zero,
  output logic               neg,
  output logic               ovf
);

  localparam logic signed [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [A_SIZE-1:0]       sel;
  logic [N-1:0]            sum;
  logic [2*N-1:0]          a_ext;
  logic [2*N-1:0]          b_ext;
  logic signed [2*N-1:0]   prod;
  logic signed [2*N-1:0]   shifted;
  logic signed [2*N-1:0]   trunc;
  logic                    add_ovf;
  logic                    mul_ovf;
  logic                    ovf_next;

  assign sel = A_SIZE'(func);

  always_comb begin
    sum     = a + b;
    add_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    a_ext   = {{N{a[N-1]}}, a};
    b_ext   = {{N{b[N-1]}}, b};
    prod    = $signed(a_ext) * $signed(b_ext);
    shifted = prod >>> (N-1);
    // Arithmetic shift floors; nudge negative inexact products back toward zero.
    if (prod[2*N-1] && (|prod[N-2:0]))
      trunc = shifted + ONE;
    else
      trunc = shifted;
    mul_ovf = !((&trunc[2*N-1:N-1]) || !(|trunc[2*N-1:N-1]));
  end

  always_comb begin
    result   = a;
    ovf_next = 1'b0;
    case (sel)
      A_SIZE'(cpuConfig::ALU_A): begin
        result   = a;
        ovf_next = 1'b0;
      end
      A_SIZE'(cpuConfig::ALU_B): begin
        result   = b;
        ovf_next = 1'b0;
      end
      A_SIZE'(cpuConfig::ALU_ADD): begin
        result   = sum;
        ovf_next = add_ovf;
      end
      A_SIZE'(cpuConfig::ALU_MUL): begin
        result   = trunc[N-1:0];
        ovf_next = mul_ovf;
      end
      default: begin
        result   = a;
        ovf_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if (flag_en) begin
      zero <= (result == '0);
      neg  <= result[N-1];
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results queued when stimulus is driven,
// popped and compared against the combinational output; flags tracked per clock.
module tb_alu;
  localparam int N = 8;

  typedef struct {
    string        tag;
    logic [N-1:0] res;
  } exp_t;

  logic                clk;
  logic                nReset;
  logic [N-1:0]        a;
  logic [N-1:0]        b;
  cpuConfig::aluFunc_t func;
  logic                flag_en;
  logic [N-1:0]        result;
  logic                zero;
  logic                neg;
  logic                ovf;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic pend_z, pend_n, pend_o;
  logic exp_z, exp_n, exp_o;

  alu #(.N(N), .A_SIZE(2)) dut (
    .clk(clk), .nReset(nReset), .a(a), .b(b), .func(func),
    .flag_en(flag_en), .result(result), .zero(zero), .neg(neg), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Reference model in integer arithmetic; '/' on int truncates toward zero.
  task automatic model(input cpuConfig::aluFunc_t f, input logic [N-1:0] av,
                       input logic [N-1:0] bv, output logic [N-1:0] r,
                       output logic z, output logic n, output logic o);
    int sa, sbv, s, p, q;
    sa  = $signed(av);
    sbv = $signed(bv);
    o   = 1'b0;
    case (f)
      cpuConfig::ALU_B:   r = bv;
      cpuConfig::ALU_ADD: begin
        s = sa + sbv;
        r = s[N-1:0];
        o = (s > 2**(N-1)-1) || (s < -(2**(N-1)));
      end
      cpuConfig::ALU_MUL: begin
        p = sa * sbv;
        q = p / (2**(N-1));
        r = q[N-1:0];
        o = (q > 2**(N-1)-1) || (q < -(2**(N-1)));
      end
      default: r = av;
    endcase
    z = (r == 0);
    n = r[N-1];
  endtask

  task automatic drive(input cpuConfig::aluFunc_t f, input logic [N-1:0] av,
                       input logic [N-1:0] bv, input string tag,
                       input bit use_const, input logic [N-1:0] const_res);
    exp_t e;
    exp_t got;
    logic [N-1:0] mr;
    @(negedge clk);
    func = f;
    a    = av;
    b    = bv;
    model(f, av, bv, mr, pend_z, pend_n, pend_o);
    e.tag = tag;
    e.res = use_const ? const_res : mr;
    sb.push_back(e);
    #1;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, result);
    end else begin
      got = sb.pop_front();
      assert (result === got.res) else begin
        mismatched++;
        $error("FAIL %s: observed result %h expected %h", got.tag, result, got.res);
      end
    end
  endtask

  task automatic step(input logic en, input string tag);
    flag_en = en;
    @(posedge clk);
    #1;
    if (!nReset) begin
      exp_z = 1'b0; exp_n = 1'b0; exp_o = 1'b0;
    end else if (en) begin
      exp_z = pend_z; exp_n = pend_n; exp_o = pend_o;
    end
    check_bit({tag, ".zero"}, zero, exp_z);
    check_bit({tag, ".neg"},  neg,  exp_n);
    check_bit({tag, ".ovf"},  ovf,  exp_o);
  endtask

  initial begin
    nReset  = 1'b0;
    flag_en = 1'b0;
    a       = '0;
    b       = '0;
    func    = cpuConfig::ALU_A;
    exp_z = 1'b0; exp_n = 1'b0; exp_o = 1'b0;
    pend_z = 1'b0; pend_n = 1'b0; pend_o = 1'b0;
    #3;
    check_bit("reset.zero", zero, 1'b0);
    check_bit("reset.neg",  neg,  1'b0);
    check_bit("reset.ovf",  ovf,  1'b0);
    @(negedge clk);
    nReset = 1'b1;

    drive(cpuConfig::ALU_ADD, 8'd10, 8'd5, "add_10_5", 1, 8'h0F);
    step(1'b1, "add_10_5");
    drive(cpuConfig::ALU_MUL, 8'h60, 8'd6, "mul_0.75x6", 1, 8'h04);
    step(1'b1, "mul_0.75x6");
    drive(cpuConfig::ALU_MUL, 8'hC0, 8'd5, "mul_-0.5x5", 1, 8'hFE);
    step(1'b1, "mul_-0.5x5");
    drive(cpuConfig::ALU_ADD, 8'h7F, 8'h01, "add_ovf", 1, 8'h80);
    step(1'b1, "add_ovf");
    drive(cpuConfig::ALU_A, 8'h00, 8'h11, "pass_a_hold", 1, 8'h00);
    step(1'b0, "hold1");
    step(1'b0, "hold2");
    step(1'b1, "pass_a_zero");

    @(negedge clk);
    #2;
    nReset = 1'b0;
    #1;
    exp_z = 1'b0; exp_n = 1'b0; exp_o = 1'b0;
    check_bit("async_rst.zero", zero, 1'b0);
    check_bit("async_rst.neg",  neg,  1'b0);
    check_bit("async_rst.ovf",  ovf,  1'b0);
    drive(cpuConfig::ALU_ADD, 8'h33, 8'h44, "in_reset_add", 1, 8'h77);
    drive(cpuConfig::ALU_B, 8'h00, 8'h90, "in_reset_b", 1, 8'h90);
    step(1'b1, "in_reset_clk");
    @(negedge clk);
    nReset = 1'b1;
    step(1'b0, "post_rst_noen");
    step(1'b1, "post_rst_first");

    drive(cpuConfig::ALU_B, 8'h00, 8'h5A, "pass_b", 1, 8'h5A);
    step(1'b1, "pass_b");
    drive(cpuConfig::ALU_MUL, 8'h80, 8'h80, "mul_boundary", 1, 8'h80);
    step(1'b1, "mul_boundary");
    drive(cpuConfig::ALU_MUL, 8'h80, 8'h7F, "mul_-1x127", 1, 8'h81);
    step(1'b1, "mul_-1x127");
    drive(cpuConfig::ALU_ADD, 8'h80, 8'hFF, "add_negovf", 1, 8'h7F);
    step(1'b1, "add_negovf");

    for (int i = 0; i < 24; i++) begin
      drive(cpuConfig::aluFunc_t'($urandom_range(0, 3)), N'($urandom),
            N'($urandom), $sformatf("rand%0d", i), 0, '0);
      step(1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter N, default 8: data width in bits; N >= 4.
REQ-002 Parameter A_SIZE, default 2: width of the func select.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port nReset, input, 1: asynchronous, active-low reset.
REQ-005 Port a, input, N: operand A.
REQ-006 Port b, input, N: operand B.
REQ-007 Port func, input, A_SIZE, type cpuConfig::aluFunc_t: operation select.
REQ-008 Port flag_en, input, 1: when high, the flag register captures this cycle's flags.
REQ-009 Port result, output, N: operation result, combinational.
REQ-010 Port zero, output, 1: registered zero flag.
REQ-011 Port neg, output, 1: registered negative flag.
REQ-012 Port ovf, output, 1: registered signed-overflow flag.

Function
REQ-013 The func encoding is fixed: ALU_A=0 (pass a), ALU_B=1 (pass b), ALU_ADD=2, ALU_MUL=3.
REQ-014 result is purely combinational from a, b, func: zero-cycle latency, independent of clk and nReset.
REQ-015 ALU_A: result = a.
REQ-016 ALU_B: result = b.
REQ-017 ALU_ADD: result = (a + b) mod 2^N, two's complement; the carry out is discarded from result.
REQ-018 ALU_MUL: a is signed fixed-point Q1.(N-1), with value a/2^(N-1), range [-1, 1); b is a signed N-bit integer.
REQ-019 ALU_MUL: form the exact 2N-bit signed product a*b, then divide by 2^(N-1), truncating toward zero (not floor); result is the low N bits.
REQ-020 ALU_MUL truncation toward zero: if the product is negative and any of its low N-1 bits are nonzero, add 1 after the arithmetic right shift.
REQ-021 ALU_MUL boundary: a = -1.0 (0x80 for N=8) with b = -2^(N-1) overflows; result wraps to the low N bits of the exact value.
REQ-022 Combinational next-flags: zero = (result == 0); neg = result[N-1].
REQ-023 Next ovf for ALU_ADD: set when a and b have the same sign and result's sign differs.
REQ-024 Next ovf for ALU_MUL: set when the truncated value does not fit in signed N bits.
REQ-025 Next ovf for ALU_A and ALU_B: 0.
REQ-026 On a rising clk edge with flag_en=1, zero/neg/ovf load the next-flags; with flag_en=0 they hold.
REQ-027 An unknown or out-of-range func value drives result = a and next ovf = 0.

Reset
REQ-028 While nReset=0, zero, neg and ovf are 0 immediately, without waiting for a clock edge.
REQ-029 Reset asserted mid-operation clears the flags asynchronously; result keeps following its inputs.
REQ-030 After nReset deasserts, the first flag update occurs at the first rising clk edge with flag_en=1.

Verification
REQ-031 ALU_ADD, a=10, b=5 -> result=15; after a clock edge with flag_en=1: zero=0, neg=0, ovf=0.
REQ-032 ALU_MUL, a=0x60 (0.75), b=6 -> result=0x04 (4.5 truncated to 4).
REQ-033 ALU_MUL, a=0xC0 (-0.5), b=5 -> result=0xFE (-2.5 truncated to -2); after a clock edge with flag_en=1: neg=1.
REQ-034 ALU_ADD, a=0x7F, b=0x01 -> result=0x80; after a clock edge with flag_en=1: ovf=1, neg=1. Next, ALU_A with a=0 and flag_en=0 -> flags unchanged over 2 clocks.
REQ-035 ALU_A, a=0x00 -> result=0x00; flag_en=1 and a clock edge -> zero=1. Then drive nReset low between clock edges -> all flags 0 immediately.
REQ-036 ALU_B, b=0x5A -> result=0x5A. ALU_MUL, a=0x80, b=0x80 -> ovf=1 after a flagged clock edge.
